// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and default width for the multiply/divide unit
package muldiv_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: register-file side operand/command bus and HI/LO result bus
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::WIDTH);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Rs;
  logic [WIDTH-1:0] Rt;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] dataIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, Rs, Rt, hiWrite, loWrite, dataIn, input busy, done, hi, lo);
  modport slave(input start, op, Rs, Rt, hiWrite, loWrite, dataIn, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               bit_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_o
);
  logic [2*WIDTH-1:0] sh, ext;
  assign sh    = {acc_i[2*WIDTH-2:0], bit_i};
  assign ext   = {{WIDTH{1'b0}}, opnd_i};
  assign q_o   = div_i && sh >= ext;
  assign acc_o = div_i ? (q_o ? sh - ext : sh) : {acc_i[2*WIDTH-2:0], 1'b0} + (bit_i ? ext : '0);
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int ITERS = WIDTH
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(ITERS + 1);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_n, prod;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   quo_raw, quo, rem, rs_mag, rt_mag;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic               q_n, sgn, sa, sb, dz;
  assign sgn    = bus.op == OP_MULT || bus.op == OP_DIV;
  assign sa     = sgn & bus.Rs[WIDTH-1];
  assign sb     = sgn & bus.Rt[WIDTH-1];
  assign rs_mag = sa ? -bus.Rs : bus.Rs;
  assign rt_mag = sb ? -bus.Rt : bus.Rt;
  // a_q is the multiplier/dividend shifted out MSB-first while quotient bits shift in
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .bit_i (a_q[WIDTH-1]),
    .opnd_i(b_q),
    .div_i (div_q),
    .acc_o (acc_n),
    .q_o   (q_n)
  );
  // divide-by-zero keeps the raw magnitude path, so sign fix-up is skipped
  assign dz      = b_q == '0;
  assign quo_raw = {a_q[WIDTH-2:0], q_n};
  assign prod    = neg_q ? -acc_n : acc_n;
  assign quo     = neg_q && !dz ? -quo_raw : quo_raw;
  assign rem     = rneg_q && !dz ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == FIN;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        hi_d = bus.hiWrite ? bus.dataIn : hi_q;
        lo_d = bus.loWrite ? bus.dataIn : lo_q;
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = CW'(ITERS - 1);
          acc_d   = '0;
          a_d     = rs_mag;
          b_d     = rt_mag;
          div_d   = bus.op[1];
          neg_d   = sa ^ sb;
          rneg_d  = sa;
        end
      end
      RUN: begin
        acc_d = acc_n;
        a_d   = quo_raw;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          {hi_d, lo_d} = div_q ? {rem, quo} : prod;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int ITERS = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_op(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: return b == 0 ? {32'(sa < 0 ? -sa : sa), 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: return b == 0 ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  bit          m_active = 0, m_done = 0, was_fin;
  int          m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] pend = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_rem = 0; m_done = 0; m_hi = 0; m_lo = 0;
    end else begin
      was_fin = m_done;
      m_done  = 0;
      if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          m_active = 0; m_done = 1; {m_hi, m_lo} = pend;
        end
      end else if (!was_fin) begin
        if (bus.hiWrite) m_hi = bus.dataIn;
        if (bus.loWrite) m_lo = bus.dataIn;
        if (bus.start) begin
          pend = ref_op(bus.op, bus.Rs, bus.Rt); m_active = 1; m_rem = ITERS;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy", 64'(bus.busy), 64'(m_active));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input string name, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    bus.start = 1; bus.op = o; bus.Rs = a; bus.Rt = b;
    tick();
    bus.start = 0; bus.op = 2'($urandom); bus.Rs = $urandom; bus.Rt = $urandom;
    chk({name, " busy1"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
    chk({name, " latency"}, 64'(lat), 64'd33);
    chk({name, " hi"}, 64'(bus.hi), 64'(eh));
    chk({name, " lo"}, 64'(bus.lo), 64'(el));
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  lat;
    bit  seen;
    bus.start = 0; bus.op = 0; bus.Rs = 0; bus.Rt = 0;
    bus.hiWrite = 0; bus.loWrite = 0; bus.dataIn = 0;
    repeat (3) tick();
    reset = 0;
    chk_en = 1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    tick();
    chk("model mult", ref_op(2'd0, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    chk("model div", ref_op(2'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max", 32'hFFFFFFFE, 32'h00000001);
    run(2'd0, 32'hFFFFFFFD, 32'd7, "mult neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
    run(2'd3, 32'd100, 32'd7, "divu", 32'd2, 32'd14);
    run(2'd2, 32'hFFFFFFF9, 32'd2, "div neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(2'd2, 32'h80000000, 32'hFFFFFFFF, "div ovf", 32'h0, 32'h80000000);
    run(2'd3, 32'd5, 32'd0, "divu zero", 32'd5, 32'hFFFFFFFF);
    run(2'd2, 32'hFFFFFFF9, 32'd0, "div zero", 32'd7, 32'hFFFFFFFF);
    bus.start = 1; bus.op = 2'd1; bus.Rs = 2; bus.Rt = 3;
    tick();
    bus.start = 0;
    repeat (9) tick();
    bus.start = 1; bus.Rs = 9; bus.Rt = 9; bus.hiWrite = 1; bus.dataIn = 32'h1234;
    tick();
    bus.start = 0; bus.hiWrite = 0;
    wait_done(lat);
    chk("interfere done", 64'(bus.done), 64'd1);
    chk("interfere hi", 64'(bus.hi), 64'd0);
    chk("interfere lo", 64'(bus.lo), 64'd6);
    bus.start = 1; bus.Rs = 7; bus.Rt = 7;
    tick();
    bus.start = 0;
    chk("start in fin ignored", 64'(bus.busy), 64'd0);
    bus.loWrite = 1; bus.dataIn = 32'hABCD;
    tick();
    bus.loWrite = 0;
    chk("mtlo lo", 64'(bus.lo), 64'hABCD);
    chk("mtlo hi", 64'(bus.hi), 64'd0);
    bus.start = 1; bus.op = 2'd2; bus.Rs = 100; bus.Rt = 3;
    tick();
    bus.start = 0;
    repeat (9) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      seen |= bus.done;
    end
    chk("no done after abort", 64'(seen), 64'd0);
    run(2'd1, 32'd4, 32'd5, "multu after abort", 32'd0, 32'd20);
    for (int i = 0; i < 4000; i++) begin
      reset        = $urandom_range(0, 999) == 0;
      bus.start    = $urandom_range(0, 3) == 0;
      bus.op       = 2'($urandom);
      bus.Rs       = pick();
      bus.Rt       = pick();
      bus.hiWrite  = $urandom_range(0, 7) == 0;
      bus.loWrite  = $urandom_range(0, 7) == 0;
      bus.dataIn   = $urandom;
      tick();
    end
    reset = 0; bus.start = 0; bus.hiWrite = 0; bus.loWrite = 0;
    repeat (40) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
